// File: rtl/brake_pkg.sv
// Shared types and default constants for the brake actuator and its slip detector.
package brake_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        APPLY   = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } actuator_state_e;

    localparam int         DEF_RAMP_DIV       = 4;
    localparam int         DEF_SAMPLE_PERIOD  = 8;
    localparam logic [7:0] DEF_SLIP_DELTA     = 8'd10;
    localparam logic [7:0] DEF_MIN_SPEED      = 8'd5;
    localparam int         DEF_RELEASE_CYCLES = 6;
    localparam logic [3:0] DEF_MAX_PRESSURE   = 4'd15;

    // Width of a counter running 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/speed_slip_detector.sv
// Samples wheel speed once per SAMPLE_PERIOD and flags a slip when the drop since
// the previous sample exceeds SLIP_DELTA; slip is a one-cycle combinational pulse.
module speed_slip_detector
    import brake_pkg::*;
#(
    parameter int         SAMPLE_PERIOD = DEF_SAMPLE_PERIOD,
    parameter logic [7:0] SLIP_DELTA    = DEF_SLIP_DELTA,
    parameter logic [7:0] MIN_SPEED     = DEF_MIN_SPEED
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] wheel_speed,
    output logic       slip
);

    localparam int            CW   = cnt_width(SAMPLE_PERIOD);
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_PERIOD - 1);

    logic [CW-1:0] sample_cnt_q, sample_cnt_d;
    logic [7:0]    prev_speed_q, prev_speed_d;
    logic          sample_pt;

    always_comb begin
        sample_pt    = (sample_cnt_q == LAST);
        sample_cnt_d = sample_pt ? '0 : sample_cnt_q + 1'b1;
        prev_speed_d = sample_pt ? wheel_speed : prev_speed_q;
        slip         = 1'b0;
        // Subtraction only after the ordering test, so it can never wrap.
        if (sample_pt && (prev_speed_q >= MIN_SPEED) && (prev_speed_q > wheel_speed)) begin
            slip = ((prev_speed_q - wheel_speed) > SLIP_DELTA);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt_q <= '0;
            prev_speed_q <= '0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            prev_speed_q <= prev_speed_d;
        end
    end

endmodule

// File: rtl/brake_actuator.sv
// Hydraulic valve-pair sequencer: ramps pressure while braking, holds at maximum and
// dumps in fixed-length ABS pulses on slip. ABS_CYCLE_COUNT_EN adds an abs_cycles counter.
module brake_actuator
    import brake_pkg::*;
#(
    parameter int         RAMP_DIV       = DEF_RAMP_DIV,
    parameter int         SAMPLE_PERIOD  = DEF_SAMPLE_PERIOD,
    parameter logic [7:0] SLIP_DELTA     = DEF_SLIP_DELTA,
    parameter logic [7:0] MIN_SPEED      = DEF_MIN_SPEED,
    parameter int         RELEASE_CYCLES = DEF_RELEASE_CYCLES,
    parameter logic [3:0] MAX_PRESSURE   = DEF_MAX_PRESSURE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       brake_signal,
    input  logic [7:0] wheel_speed,
    output logic       valve_apply,
    output logic       valve_release,
    output logic [3:0] pressure,
    output logic       abs_active
`ifdef ABS_CYCLE_COUNT_EN
    ,
    output logic [7:0] abs_cycles
`endif
);

    localparam int            RW        = cnt_width(RAMP_DIV);
    localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_DIV - 1);
    localparam int            LW        = cnt_width(RELEASE_CYCLES);
    localparam logic [LW-1:0] REL_LAST  = LW'(RELEASE_CYCLES - 1);

    actuator_state_e state_q, state_d;
    logic [RW-1:0]   ramp_cnt_q, ramp_cnt_d;
    logic [LW-1:0]   rel_cnt_q, rel_cnt_d;
    logic [3:0]      pressure_q, pressure_d;
    logic            ramp_tick;
    logic            slip;

    speed_slip_detector #(
        .SAMPLE_PERIOD (SAMPLE_PERIOD),
        .SLIP_DELTA    (SLIP_DELTA),
        .MIN_SPEED     (MIN_SPEED)
    ) u_slip (
        .clk         (clk),
        .rst_n       (rst_n),
        .wheel_speed (wheel_speed),
        .slip        (slip)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (brake_signal) state_d = APPLY;
            end
            APPLY: begin
                if (!brake_signal)                  state_d = IDLE;
                else if (slip)                      state_d = RELEASE;
                else if (pressure_q == MAX_PRESSURE) state_d = HOLD;
            end
            HOLD: begin
                if (!brake_signal) state_d = IDLE;
                else if (slip)     state_d = RELEASE;
            end
            RELEASE: begin
                // Slip is deliberately not looked at here: the pulse length is fixed.
                if (!brake_signal)           state_d = IDLE;
                else if (rel_cnt_q == REL_LAST) state_d = APPLY;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ramp_tick  = (ramp_cnt_q == RAMP_LAST);
        ramp_cnt_d = ((state_d != state_q) || ramp_tick) ? '0 : ramp_cnt_q + 1'b1;
        rel_cnt_d  = ((state_q == RELEASE) && (state_d == RELEASE)) ? rel_cnt_q + 1'b1 : '0;

        pressure_d = pressure_q;
        case (state_q)
            IDLE:    if (ramp_tick && (pressure_q != 4'd0)) pressure_d = pressure_q - 4'd1;
            APPLY:   if (ramp_tick && (pressure_q < MAX_PRESSURE)) pressure_d = pressure_q + 4'd1;
            RELEASE: if (pressure_q != 4'd0) pressure_d = pressure_q - 4'd1;
            default: pressure_d = pressure_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ramp_cnt_q <= '0;
            rel_cnt_q  <= '0;
            pressure_q <= '0;
        end else begin
            state_q    <= state_d;
            ramp_cnt_q <= ramp_cnt_d;
            rel_cnt_q  <= rel_cnt_d;
            pressure_q <= pressure_d;
        end
    end

    // Outputs decode registered state only, so the two valves are mutually exclusive by construction.
    assign valve_apply   = (state_q == APPLY) && (pressure_q < MAX_PRESSURE);
    assign valve_release = (state_q == RELEASE) || ((state_q == IDLE) && (pressure_q != 4'd0));
    assign abs_active    = (state_q == RELEASE);
    assign pressure      = pressure_q;

`ifdef ABS_CYCLE_COUNT_EN
    logic [7:0] abs_cycles_q, abs_cycles_d;

    always_comb begin
        abs_cycles_d = abs_cycles_q;
        if ((state_q != RELEASE) && (state_d == RELEASE) && (abs_cycles_q != 8'hFF)) begin
            abs_cycles_d = abs_cycles_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) abs_cycles_q <= '0;
        else        abs_cycles_q <= abs_cycles_d;
    end

    assign abs_cycles = abs_cycles_q;
`endif

endmodule

// File: tb/tb_brake_actuator.sv
// Scenario bench for brake_actuator: expected per-cycle outputs are queued when stimulus
// is applied and popped for comparison on the falling edge.
module tb_brake_actuator;

    typedef struct packed {
        logic [3:0] p;
        logic       va;
        logic       vr;
        logic       ab;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       brake_signal = 1'b0;
    logic [7:0] wheel_speed = 8'd0;
    logic       valve_apply, valve_release, abs_active;
    logic [3:0] pressure;
`ifdef ABS_CYCLE_COUNT_EN
    logic [7:0] abs_cycles;
`endif

    obs_t obs;
    obs_t e;
    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   edge_cnt = 0;
    int   exp_abs  = 0;

    always #5 clk = ~clk;

    brake_actuator dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .brake_signal  (brake_signal),
        .wheel_speed   (wheel_speed),
        .valve_apply   (valve_apply),
        .valve_release (valve_release),
        .pressure      (pressure),
        .abs_active    (abs_active)
`ifdef ABS_CYCLE_COUNT_EN
        ,
        .abs_cycles    (abs_cycles)
`endif
    );

    assign obs = {pressure, valve_apply, valve_release, abs_active};

    // Rising edges since reset release; the DUT samples speed on every 8th one.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    function automatic obs_t mk(input int p, input bit va, input bit vr, input bit ab);
        obs_t r;
        r.p  = 4'(p);
        r.va = va;
        r.vr = vr;
        r.ab = ab;
        return r;
    endfunction

    function automatic int min15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    // Park on a falling edge whose following rising edge is a speed sample point.
    task automatic wait_sample_next();
        for (int i = 0; i < 8 && (edge_cnt % 8) != 7; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        brake_signal = 1'b0;
        wheel_speed = 8'd60;
        repeat (3) @(negedge clk);
        n_checks++;
        if (obs !== mk(0, 0, 0, 0))
            $display("FAIL reset_hold: got p=%0d va=%b vr=%b abs=%b, expected all 0", obs.p, obs.va, obs.vr, obs.ab);
        else n_pass++;
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) exp_q.push_back(mk(0, 0, 0, 0));
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e)
                $display("FAIL reset_idle[%0d]: got p=%0d va=%b vr=%b abs=%b, expected p=%0d va=%b vr=%b abs=%b",
                         k, obs.p, obs.va, obs.vr, obs.ab, e.p, e.va, e.vr, e.ab);
            else n_pass++;
        end
        $display("test_reset: done, %0d/%0d so far", n_pass, n_checks);
    endtask

    task automatic test_apply();
        brake_signal = 1'b1;
        for (int k = 0; k < 66; k++) exp_q.push_back(mk(min15(k / 4), k < 60, 0, 0));
        for (int k = 0; k < 66; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e)
                $display("FAIL apply[%0d]: got p=%0d va=%b vr=%b abs=%b, expected p=%0d va=%b vr=%b abs=%b",
                         k, obs.p, obs.va, obs.vr, obs.ab, e.p, e.va, e.vr, e.ab);
            else n_pass++;
        end
        $display("test_apply: done, %0d/%0d so far", n_pass, n_checks);
    endtask

    // A drop of exactly SLIP_DELTA must not count as slip.
    task automatic test_slip_boundary();
        wait_sample_next();
        wheel_speed = 8'd50;
        for (int k = 0; k < 8; k++) exp_q.push_back(mk(15, 0, 0, 0));
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e)
                $display("FAIL slip_delta_eq[%0d]: got p=%0d va=%b vr=%b abs=%b, expected p=%0d va=%b vr=%b abs=%b",
                         k, obs.p, obs.va, obs.vr, obs.ab, e.p, e.va, e.vr, e.ab);
            else n_pass++;
        end
        $display("test_slip_boundary: done, %0d/%0d so far", n_pass, n_checks);
    endtask

    task automatic test_slip_release();
        int p;
        wait_sample_next();
        wheel_speed = 8'd39;
        exp_abs++;
        for (int j = 0; j < 32; j++) begin
            p = (j < 6) ? 15 - j : min15(9 + (j - 6) / 4);
            exp_q.push_back(mk(p, (j >= 6) && (j < 30), j < 6, j < 6));
        end
        for (int j = 0; j < 32; j++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e)
                $display("FAIL abs_pulse[%0d]: got p=%0d va=%b vr=%b abs=%b, expected p=%0d va=%b vr=%b abs=%b",
                         j, obs.p, obs.va, obs.vr, obs.ab, e.p, e.va, e.vr, e.ab);
            else n_pass++;
        end
`ifdef ABS_CYCLE_COUNT_EN
        n_checks++;
        if (abs_cycles !== 8'(exp_abs))
            $display("FAIL abs_cycles_after_pulse: got %0d, expected %0d", abs_cycles, exp_abs);
        else n_pass++;
`endif
        $display("test_slip_release: done, %0d/%0d so far", n_pass, n_checks);
    endtask

    task automatic test_min_speed();
        logic [7:0] speeds [5] = '{8'd29, 8'd19, 8'd9, 8'd4, 8'd0};
        for (int s = 0; s < 5; s++) begin
            wait_sample_next();
            wheel_speed = speeds[s];
            for (int k = 0; k < 8; k++) exp_q.push_back(mk(15, 0, 0, 0));
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                e = exp_q.pop_front();
                n_checks++;
                if (obs !== e)
                    $display("FAIL low_speed[%0d.%0d]: got p=%0d va=%b vr=%b abs=%b, expected p=%0d va=%b vr=%b abs=%b",
                             s, k, obs.p, obs.va, obs.vr, obs.ab, e.p, e.va, e.vr, e.ab);
                else n_pass++;
            end
        end
        $display("test_min_speed: done, %0d/%0d so far", n_pass, n_checks);
    endtask

    task automatic test_release_abort();
        int p;
        wait_sample_next();
        wheel_speed = 8'd60;
        repeat (8) @(negedge clk);
        wait_sample_next();
        wheel_speed = 8'd49;
        exp_abs++;
        exp_q.push_back(mk(15, 0, 1, 1));
        exp_q.push_back(mk(14, 0, 1, 1));
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e)
                $display("FAIL abort_pulse[%0d]: got p=%0d va=%b vr=%b abs=%b, expected p=%0d va=%b vr=%b abs=%b",
                         j, obs.p, obs.va, obs.vr, obs.ab, e.p, e.va, e.vr, e.ab);
            else n_pass++;
        end
        brake_signal = 1'b0;
        for (int m = 0; m < 57; m++) begin
            p = 13 - m / 4;
            if (p < 0) p = 0;
            exp_q.push_back(mk(p, 0, p != 0, 0));
        end
        for (int m = 0; m < 57; m++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e)
                $display("FAIL bleed[%0d]: got p=%0d va=%b vr=%b abs=%b, expected p=%0d va=%b vr=%b abs=%b",
                         m, obs.p, obs.va, obs.vr, obs.ab, e.p, e.va, e.vr, e.ab);
            else n_pass++;
        end
        $display("test_release_abort: done, %0d/%0d so far", n_pass, n_checks);
    endtask

    task automatic test_reset_mid_apply();
        brake_signal = 1'b1;
        for (int k = 0; k < 10; k++) exp_q.push_back(mk(k / 4, 1, 0, 0));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e)
                $display("FAIL pre_reset_apply[%0d]: got p=%0d va=%b vr=%b abs=%b, expected p=%0d va=%b vr=%b abs=%b",
                         k, obs.p, obs.va, obs.vr, obs.ab, e.p, e.va, e.vr, e.ab);
            else n_pass++;
        end
`ifdef ABS_CYCLE_COUNT_EN
        n_checks++;
        if (abs_cycles !== 8'(exp_abs))
            $display("FAIL abs_cycles_before_reset: got %0d, expected %0d", abs_cycles, exp_abs);
        else n_pass++;
`endif
        #2 rst_n = 1'b0;
        exp_abs = 0;
        exp_q.push_back(mk(0, 0, 0, 0));
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e)
            $display("FAIL async_reset: got p=%0d va=%b vr=%b abs=%b, expected all 0", obs.p, obs.va, obs.vr, obs.ab);
        else n_pass++;
`ifdef ABS_CYCLE_COUNT_EN
        n_checks++;
        if (abs_cycles !== 8'd0)
            $display("FAIL abs_cycles_reset: got %0d, expected 0", abs_cycles);
        else n_pass++;
`endif
        repeat (2) @(negedge clk);
        brake_signal = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) exp_q.push_back(mk(0, 0, 0, 0));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e)
                $display("FAIL post_reset[%0d]: got p=%0d va=%b vr=%b abs=%b, expected all 0",
                         k, obs.p, obs.va, obs.vr, obs.ab);
            else n_pass++;
        end
        $display("test_reset_mid_apply: done, %0d/%0d so far", n_pass, n_checks);
    endtask

`ifdef ABS_CYCLE_COUNT_EN
    task automatic test_abs_count();
        logic [7:0] drops [3] = '{8'd180, 8'd160, 8'd140};
        wheel_speed = 8'd200;
        brake_signal = 1'b1;
        wait_sample_next();
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            wait_sample_next();
            wheel_speed = drops[s];
            exp_abs++;
            exp_q.push_back(mk(0, 0, 1, 1));
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if (obs.ab !== e.ab || obs.vr !== e.vr || obs.va !== e.va)
                $display("FAIL abs_event[%0d]: got va=%b vr=%b abs=%b, expected va=0 vr=1 abs=1",
                         s, obs.va, obs.vr, obs.ab);
            else n_pass++;
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (abs_cycles !== 8'(exp_abs))
            $display("FAIL abs_cycles_three: got %0d, expected %0d", abs_cycles, exp_abs);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (abs_cycles !== 8'd0)
            $display("FAIL abs_cycles_cleared: got %0d, expected 0", abs_cycles);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        brake_signal = 1'b0;
        $display("test_abs_count: done, %0d/%0d so far", n_pass, n_checks);
    endtask
`endif

    initial begin
        test_reset();
        test_apply();
        test_slip_boundary();
        test_slip_release();
        test_min_speed();
        test_release_abort();
        test_reset_mid_apply();
`ifdef ABS_CYCLE_COUNT_EN
        test_abs_count();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
